wb_bus_splitter_n: RTL and testbench
====================================

# wb_bus_splitter_n

Parametrised, registered Wishbone classic 1-to-N bus splitter for the user-project peripheral bus. It decodes each master cycle against per-slave base/mask pairs and locks the transaction to one slave until that slave terminates it. It also returns an error for unmapped addresses, and optionally returns an error for slaves that never respond. It replaces fixed 4-port combinational splitting and sits between the management-core Wishbone master and the peripheral slaves.

## Interface
- N_SLAVES, 4: number of slave ports, 1..16; SW = max(1, $clog2(N_SLAVES)).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- SEL_WIDTH, DATA_WIDTH/8: byte-select width.
- BASE_ADDRS, {32'h3003_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000}: flattened N_SLAVES*ADDR_WIDTH; slave i base at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ADDR_MASKS, {4{32'hFFFF_0000}}: flattened per-slave masks, same layout.
- TIMEOUT_CYCLES, 255: cycles in ACTIVE without ack/err before abort, 1..65535.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_wb_adr / m_wb_dat_w / m_wb_we / m_wb_sel / m_wb_cyc / m_wb_stb  in  ADDR_WIDTH / DATA_WIDTH / 1 / SEL_WIDTH / 1 / 1  master request.
- m_wb_dat_r  out  DATA_WIDTH  read data, valid only with m_wb_ack.
- m_wb_ack / m_wb_err  out  1  registered one-cycle termination pulses.
- s_wb_adr  out  N_SLAVES*ADDR_WIDTH  per-slave address, flattened.
- s_wb_dat_w  out  N_SLAVES*DATA_WIDTH  per-slave write data.
- s_wb_dat_r  in  N_SLAVES*DATA_WIDTH  per-slave read data.
- s_wb_we / s_wb_cyc / s_wb_stb  out  N_SLAVES  per-slave controls.
- s_wb_sel  out  N_SLAVES*SEL_WIDTH  per-slave byte selects.
- s_wb_ack / s_wb_err  in  N_SLAVES  per-slave terminations.
- stat_timeout  out  1  one-cycle pulse when a timeout abort terminates a cycle.
- stat_sel  out  SW  index of the slave in the most recent decoded transaction.

## Operation
- Decode: hit_i = ((m_wb_adr & MASK_i) == (BASE_i & MASK_i)). The lowest index wins on overlap.
- FSM states are IDLE, ACTIVE and RESP.
- IDLE, when m_wb_cyc & m_wb_stb:
  - On a hit, latch adr, dat_w, we, sel and the index; update stat_sel; go to ACTIVE.
  - On a miss, go to RESP with err pending; no slave is touched.
- ACTIVE: only the latched slave sees cyc=stb=1 and the latched adr, dat_w, we and sel. All other slave outputs are 0.
  - slave err: capture it, drop slave cyc/stb, go to RESP with err.
  - slave ack (and no err): capture s_wb_dat_r, drop slave cyc/stb, go to RESP with ack.
  - If err and ack arrive in the same cycle, err wins.
  - If m_wb_cyc falls, abort: drop slave outputs, go to IDLE, no master termination.
- RESP: assert m_wb_ack or m_wb_err for exactly one cycle, then go to IDLE.
  - m_wb_dat_r carries the captured data on ack and is 0 otherwise.
  - Master request inputs are ignored in RESP.
- Reset, including mid-transaction: state IDLE; every output 0, including m_wb_dat_r, all s_wb_* outputs, stat_timeout and stat_sel. A pending termination is dropped.

## Timing
- Master stb sampled in IDLE at edge 0 → slave stb high from edge 1.
- Slave ack sampled at edge k (k ≥ 1) → m_wb_ack high for the cycle after edge k+1 → IDLE at edge k+2.
- Zero-wait slave: master ack appears 2 cycles after master stb.
- Unmapped: m_wb_err is high for the cycle after edge 1 (one cycle after the request is sampled).
- Back-to-back: a new request can be sampled at the first IDLE edge after RESP. That gives 1 dead cycle between cycles.
- Slave cyc/stb deassert on the same edge that enters RESP. They are never high for more than one cycle after ack/err is sampled.

## Configuration
- WB_SPLIT_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering ACTIVE and increments each ACTIVE cycle.
  - When the count reaches TIMEOUT_CYCLES with no ack/err that cycle, drop slave cyc/stb and go to RESP with err. stat_timeout pulses in the RESP cycle.
  - If ack or err arrives in that same cycle, it wins over the timeout.
- Undefined: no counter is built; ACTIVE waits indefinitely; stat_timeout is tied to 0.

## Test plan
- Write 0x3001_0004 ← 0xDEADBEEF, slave1 acks at its first stb cycle → only s_wb_stb[1] rises; adr, dat and sel are forwarded; m_wb_ack pulses 2 cycles after master stb; stat_sel=1.
- Read 0x3003_0010, slave3 acks after 5 wait cycles with data 0xA5A5_0003 → m_wb_dat_r=0xA5A5_0003 with a 1-cycle m_wb_ack; zero outside that cycle.
- Access 0x4000_0000 → m_wb_err pulses 1 cycle after the request; all s_wb_cyc stay 0.
- Slave2 asserts ack and err together → m_wb_err=1, m_wb_ack=0.
- With WB_SPLIT_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave0 never acks → after 8 ACTIVE cycles, s_wb_stb[0] drops, m_wb_err and stat_timeout pulse together, and the next request is accepted.
- rst during ACTIVE, and m_wb_cyc dropped during ACTIVE → outputs 0 next cycle, state IDLE, no ack/err emitted.

Source files
------------

// File: rtl/wb_bus_splitter_n_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_splitter_n_if
// Description : Bundle of Wishbone classic signals around the 1-to-N splitter.
//               Master side: m_wb_* (request from the management core and the
//               response returned to it). Slave side: s_wb_* flattened per-slave
//               vectors, slave i at [i*WIDTH +: WIDTH].
//               Modport slave  : view of the splitter (responds to the master,
//                                drives the peripheral slaves).
//               Modport master : view of the surrounding system (drives the
//                                master request and the slave responses).
// Revision    : 1.0  initial release
// ============================================================================
interface wb_bus_splitter_n_if #(
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    // Master request / response
    logic [ADDR_WIDTH-1:0]          m_wb_adr;
    logic [DATA_WIDTH-1:0]          m_wb_dat_w;
    logic                           m_wb_we;
    logic [SEL_WIDTH-1:0]           m_wb_sel;
    logic                           m_wb_cyc;
    logic                           m_wb_stb;
    logic [DATA_WIDTH-1:0]          m_wb_dat_r;
    logic                           m_wb_ack;
    logic                           m_wb_err;

    // Per-slave request / response, flattened
    logic [N_SLAVES*ADDR_WIDTH-1:0] s_wb_adr;
    logic [N_SLAVES*DATA_WIDTH-1:0] s_wb_dat_w;
    logic [N_SLAVES*DATA_WIDTH-1:0] s_wb_dat_r;
    logic [N_SLAVES-1:0]            s_wb_we;
    logic [N_SLAVES-1:0]            s_wb_cyc;
    logic [N_SLAVES-1:0]            s_wb_stb;
    logic [N_SLAVES*SEL_WIDTH-1:0]  s_wb_sel;
    logic [N_SLAVES-1:0]            s_wb_ack;
    logic [N_SLAVES-1:0]            s_wb_err;

    modport slave (
        input  m_wb_adr, m_wb_dat_w, m_wb_we, m_wb_sel, m_wb_cyc, m_wb_stb,
        output m_wb_dat_r, m_wb_ack, m_wb_err,
        output s_wb_adr, s_wb_dat_w, s_wb_we, s_wb_cyc, s_wb_stb, s_wb_sel,
        input  s_wb_dat_r, s_wb_ack, s_wb_err
    );

    modport master (
        output m_wb_adr, m_wb_dat_w, m_wb_we, m_wb_sel, m_wb_cyc, m_wb_stb,
        input  m_wb_dat_r, m_wb_ack, m_wb_err,
        input  s_wb_adr, s_wb_dat_w, s_wb_we, s_wb_cyc, s_wb_stb, s_wb_sel,
        output s_wb_dat_r, s_wb_ack, s_wb_err
    );
endinterface
`default_nettype wire

// File: rtl/wb_bus_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_splitter_n
// Description : Registered Wishbone classic 1-to-N bus splitter. Each master
//               cycle is decoded against per-slave base/mask pairs (lowest
//               index wins), locked to one slave until it terminates, and
//               answered with a registered one-cycle ack/err pulse. Unmapped
//               addresses are answered with err without touching any slave.
// Ports       : clk          rising-edge clock
//               rst          synchronous active-high reset
//               bus          wb_bus_splitter_n_if.slave (m_wb_* and s_wb_*)
//               stat_timeout one-cycle pulse with a timeout-generated err
//               stat_sel     slave index of the most recent decoded cycle
// Options     : WB_SPLIT_TIMEOUT_EN - when defined, a 16-bit watchdog aborts
//               an ACTIVE cycle with err after TIMEOUT_CYCLES silent cycles.
//               When undefined, ACTIVE waits indefinitely.
// Revision    : 1.0  initial release
// ============================================================================
module wb_bus_splitter_n #(
    parameter int N_SLAVES       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS =
        {32'h3003_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {4{32'hFFFF_0000}},
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    wb_bus_splitter_n_if.slave     bus,
    output logic                   stat_timeout,
    output logic [SW-1:0]          stat_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("wb_bus_splitter_n: N_SLAVES or TIMEOUT_CYCLES out of range");
    end

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_w_q;
    logic                    we_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    // One-hot owner of the current cycle; all zero outside ACTIVE. It both
    // gates the slave outputs and selects the response mux.
    logic [N_SLAVES-1:0]     s_cyc_q;
    logic                    m_ack_q;
    logic                    m_err_q;
    logic [DATA_WIDTH-1:0]   m_dat_r_q;
    logic                    timeout_q;
    logic [SW-1:0]           stat_sel_q;

    logic                    w_hit;
    logic [SW-1:0]           w_hit_idx;
    logic [N_SLAVES-1:0]     w_hit_oh;
    logic                    w_s_ack;
    logic                    w_s_err;
    logic [DATA_WIDTH-1:0]   w_s_dat;
    logic                    w_to_hit;

    // Address decode. Walking from the top index down lets the lowest
    // matching slave overwrite any higher match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_oh  = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_wb_adr & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_hit       = 1'b1;
                w_hit_idx   = SW'(i);
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
            end
        end
    end

    // Response mux from the owning slave only.
    always_comb begin
        w_s_ack = 1'b0;
        w_s_err = 1'b0;
        w_s_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_cyc_q[i]) begin
                w_s_ack = bus.s_wb_ack[i];
                w_s_err = bus.s_wb_err[i];
                w_s_dat = bus.s_wb_dat_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef WB_SPLIT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q;
    // Counter holds the number of ACTIVE cycles already completed, so the
    // TIMEOUT_CYCLES-th silent cycle is the one where it equals TO_LAST.
    assign w_to_hit = (to_cnt_q == TO_LAST);
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            dat_w_q    <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            s_cyc_q    <= '0;
            m_ack_q    <= 1'b0;
            m_err_q    <= 1'b0;
            m_dat_r_q  <= '0;
            timeout_q  <= 1'b0;
            stat_sel_q <= '0;
`ifdef WB_SPLIT_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            // Termination pulses last exactly one cycle unless set below.
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_dat_r_q <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.m_wb_cyc && bus.m_wb_stb) begin
                        if (w_hit) begin
                            adr_q      <= bus.m_wb_adr;
                            dat_w_q    <= bus.m_wb_dat_w;
                            we_q       <= bus.m_wb_we;
                            sel_q      <= bus.m_wb_sel;
                            s_cyc_q    <= w_hit_oh;
                            stat_sel_q <= w_hit_idx;
`ifdef WB_SPLIT_TIMEOUT_EN
                            to_cnt_q   <= '0;
`endif
                            state_q    <= ACTIVE;
                        end else begin
                            m_err_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    if (!bus.m_wb_cyc) begin
                        // Master gave up: release the slave silently.
                        s_cyc_q <= '0;
                        state_q <= IDLE;
                    end else if (w_s_err) begin
                        s_cyc_q <= '0;
                        m_err_q <= 1'b1;
                        state_q <= RESP;
                    end else if (w_s_ack) begin
                        s_cyc_q   <= '0;
                        m_ack_q   <= 1'b1;
                        m_dat_r_q <= w_s_dat;
                        state_q   <= RESP;
                    end else if (w_to_hit) begin
                        s_cyc_q   <= '0;
                        m_err_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
`ifdef WB_SPLIT_TIMEOUT_EN
                        to_cnt_q <= to_cnt_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    s_cyc_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Slave-side fan-out: only the owner sees the latched request.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slave
        assign bus.s_wb_cyc[i] = s_cyc_q[i];
        assign bus.s_wb_stb[i] = s_cyc_q[i];
        assign bus.s_wb_we[i]  = s_cyc_q[i] & we_q;
        assign bus.s_wb_adr[i*ADDR_WIDTH +: ADDR_WIDTH]   = s_cyc_q[i] ? adr_q   : '0;
        assign bus.s_wb_dat_w[i*DATA_WIDTH +: DATA_WIDTH] = s_cyc_q[i] ? dat_w_q : '0;
        assign bus.s_wb_sel[i*SEL_WIDTH +: SEL_WIDTH]     = s_cyc_q[i] ? sel_q   : '0;
    end

    assign bus.m_wb_ack   = m_ack_q;
    assign bus.m_wb_err   = m_err_q;
    assign bus.m_wb_dat_r = m_dat_r_q;
    assign stat_timeout   = timeout_q;
    assign stat_sel       = stat_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_splitter_n
// Description : Scoreboard bench for wb_bus_splitter_n. Requests push the
//               expected termination (kind, data, timeout flag, stat_sel and
//               the cycle it must appear in) into a queue; a negedge monitor
//               pops and compares whenever m_wb_ack or m_wb_err is seen.
//               A negedge responder models the four slaves.
//               Timeout scenario is built only with WB_SPLIT_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_bus_splitter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stat_timeout;
    logic [1:0] stat_sel;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        logic [1:0]  term;   // {ack, err}
        logic [31:0] dat;
        logic        to;
        logic [1:0]  sel;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Responder configuration: mode 0 ack, 1 err, 2 ack+err, 3 silent
    int          rsp_wait = 0;
    int          rsp_mode = 0;
    logic [31:0] rsp_data = '0;
    int          rsp_cnt  = 0;
    logic        rsp_any;
    int          nstb;

    wb_bus_splitter_n_if #(.N_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    wb_bus_splitter_n #(
        .N_SLAVES       (4),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SEL_WIDTH      (4),
        .BASE_ADDRS     ({32'h3003_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000}),
        .ADDR_MASKS     ({4{32'hFFFF_0000}}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stat_timeout (stat_timeout),
        .stat_sel     (stat_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave models: the owner responds after rsp_wait stb cycles.
    always @(negedge clk) begin
        bus.s_wb_ack = '0;
        bus.s_wb_err = '0;
        for (int i = 0; i < 4; i++) bus.s_wb_dat_r[i*32 +: 32] = {16'hBAD0, 16'(i)};
        rsp_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.s_wb_cyc[i] && bus.s_wb_stb[i]) begin
                rsp_any = 1'b1;
                if (rsp_cnt == rsp_wait && rsp_mode != 3) begin
                    if (rsp_mode == 0 || rsp_mode == 2) bus.s_wb_ack[i] = 1'b1;
                    if (rsp_mode == 1 || rsp_mode == 2) bus.s_wb_err[i] = 1'b1;
                    bus.s_wb_dat_r[i*32 +: 32] = rsp_data;
                end
            end
        end
        rsp_cnt = rsp_any ? rsp_cnt + 1 : 0;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (bus.m_wb_ack || bus.m_wb_err) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term actual ack=%0b err=%0b required none", bus.m_wb_ack, bus.m_wb_err);
            end else begin
                mon_e = sbq.pop_front();
                chk("term_kind",    {30'd0, bus.m_wb_ack, bus.m_wb_err}, {30'd0, mon_e.term});
                chk("term_dat_r",   bus.m_wb_dat_r, mon_e.dat);
                chk("term_timeout", {31'd0, stat_timeout}, {31'd0, mon_e.to});
                chk("term_sel",     {30'd0, stat_sel}, {30'd0, mon_e.sel});
                chk("term_cycle",   cyc_n, mon_e.cyc);
            end
        end else begin
            chk("idle_dat_r",   bus.m_wb_dat_r, 32'd0);
            chk("idle_timeout", {31'd0, stat_timeout}, 32'd0);
        end
    end

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat, input logic we, input logic [3:0] sel);
        @(negedge clk);
        bus.m_wb_adr   = adr;
        bus.m_wb_dat_w = dat;
        bus.m_wb_we    = we;
        bus.m_wb_sel   = sel;
        bus.m_wb_cyc   = 1'b1;
        bus.m_wb_stb   = 1'b1;
    endtask

    task automatic drop_req();
        bus.m_wb_cyc = 1'b0;
        bus.m_wb_stb = 1'b0;
        bus.m_wb_we  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we, input logic [3:0] sel,
                         input logic [1:0] term, input logic [31:0] edat, input logic eto,
                         input logic [1:0] esel, input int lat);
        exp_t e;
        drive_req(adr, dat, we, sel);
        e.term = term;
        e.dat  = edat;
        e.to   = eto;
        e.sel  = esel;
        e.cyc  = cyc_n + lat;
        sbq.push_back(e);
    endtask

    // Waits for the master termination, counting stb-high cycles before it.
    task automatic wait_term(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.m_wb_ack || bus.m_wb_err) begin
                chk("s_cyc_drop", {28'd0, bus.s_wb_cyc}, 32'd0);
                drop_req();
                return;
            end
            if (|bus.s_wb_stb) n++;
        end
        checks++;
        errors++;
        $display("FAIL term_wait actual=none required=ack_or_err");
        drop_req();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_wb_adr = '0; bus.m_wb_dat_w = '0; bus.m_wb_we = 1'b0;
        bus.m_wb_sel = '0; bus.m_wb_cyc = 1'b0; bus.m_wb_stb = 1'b0;
        bus.s_wb_ack = '0; bus.s_wb_err = '0; bus.s_wb_dat_r = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_cyc",   {28'd0, bus.s_wb_cyc}, 32'd0);
        chk("rst_ack_err", {30'd0, bus.m_wb_ack, bus.m_wb_err}, 32'd0);
        chk("rst_sel",     {30'd0, stat_sel}, 32'd0);
        rst = 1'b0;

        // Zero-wait write to slave 1
        rsp_mode = 0; rsp_wait = 0; rsp_data = 32'h0;
        issue(32'h3001_0004, 32'hDEAD_BEEF, 1'b1, 4'b0110, 2'b10, 32'h0, 1'b0, 2'd1, 2);
        @(negedge clk);
        chk("w_s_stb",  {28'd0, bus.s_wb_stb}, 32'h2);
        chk("w_s_cyc",  {28'd0, bus.s_wb_cyc}, 32'h2);
        chk("w_s_we",   {28'd0, bus.s_wb_we},  32'h2);
        chk("w_s_adr1", bus.s_wb_adr[63:32], 32'h3001_0004);
        chk("w_s_dat1", bus.s_wb_dat_w[63:32], 32'hDEAD_BEEF);
        chk("w_s_sel1", {28'd0, bus.s_wb_sel[7:4]}, 32'h6);
        chk("w_s_adr0", bus.s_wb_adr[31:0], 32'h0);
        chk("w_sel",    {30'd0, stat_sel}, 32'd1);
        wait_term(nstb);

        // Read from slave 3 with 5 wait cycles
        rsp_mode = 0; rsp_wait = 5; rsp_data = 32'hA5A5_0003;
        issue(32'h3003_0010, 32'h0, 1'b0, 4'hF, 2'b10, 32'hA5A5_0003, 1'b0, 2'd3, 7);
        wait_term(nstb);
        chk("r_stb_cycles", nstb, 6);

        // Unmapped address
        issue(32'h4000_0000, 32'h0, 1'b0, 4'hF, 2'b01, 32'h0, 1'b0, 2'd3, 1);
        wait_term(nstb);
        chk("unmapped_stb_cycles", nstb, 0);

        // Slave 2 asserts ack and err together
        rsp_mode = 2; rsp_wait = 1; rsp_data = 32'h2222_2222;
        issue(32'h3002_0008, 32'h0, 1'b0, 4'hF, 2'b01, 32'h0, 1'b0, 2'd2, 3);
        wait_term(nstb);

`ifdef WB_SPLIT_TIMEOUT_EN
        // Silent slave 0: aborted after 8 ACTIVE cycles
        rsp_mode = 3;
        issue(32'h3000_0000, 32'h0, 1'b0, 4'hF, 2'b01, 32'h0, 1'b1, 2'd0, 9);
        wait_term(nstb);
        chk("to_stb_cycles", nstb, 8);
`endif

        // Next request is accepted normally
        rsp_mode = 0; rsp_wait = 2; rsp_data = 32'h1234_5678;
        issue(32'h3001_0000, 32'h0, 1'b0, 4'hF, 2'b10, 32'h1234_5678, 1'b0, 2'd1, 4);
        wait_term(nstb);

        // Master drops cyc during ACTIVE
        rsp_mode = 3;
        drive_req(32'h3000_0100, 32'h0, 1'b0, 4'hF);
        repeat (3) @(negedge clk);
        chk("abort_active", {28'd0, bus.s_wb_cyc}, 32'h1);
        drop_req();
        @(negedge clk);
        chk("abort_s_cyc", {28'd0, bus.s_wb_cyc}, 32'd0);
        chk("abort_s_adr", bus.s_wb_adr[31:0], 32'd0);
        repeat (3) @(negedge clk);

        // Reset during ACTIVE
        drive_req(32'h3002_0000, 32'h5555_AAAA, 1'b1, 4'hF);
        repeat (2) @(negedge clk);
        chk("rst_mid_sel_before", {30'd0, stat_sel}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_s_cyc", {28'd0, bus.s_wb_cyc}, 32'd0);
        chk("rst_mid_s_dat", bus.s_wb_dat_w[95:64], 32'd0);
        chk("rst_mid_sel",   {30'd0, stat_sel}, 32'd0);
        chk("rst_mid_term",  {30'd0, bus.m_wb_ack, bus.m_wb_err}, 32'd0);
        rst = 1'b0;
        drop_req();
        repeat (3) @(negedge clk);

        // Recovery: zero-wait write to slave 3
        rsp_mode = 0; rsp_wait = 0; rsp_data = 32'h0;
        issue(32'h3003_0000, 32'h0000_0033, 1'b1, 4'hF, 2'b10, 32'h0, 1'b0, 2'd3, 2);
        wait_term(nstb);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
